sequence_checker: RTL and testbench
===================================

Name: sequence_checker

Overview:
- Game controller for PlaySeq. It steps a registered 16x4 sequence ROM through its addresses and compares each one-hot ROM word with the player's button press.
- It reports hit, miss or timeout at the end of a round.
- It sits directly upstream of the sequence ROM: it drives the ROM address and consumes its data output.

Parameters:
SEQ_LEN, 16, number of plays per round (1..16); addresses 0..SEQ_LEN-1 are used.
TIMEOUT, 5000, clock cycles allowed in ESPERA_JOGADA before the round is lost.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; forces INICIAL.
iniciar  in  1  start request, synchronous level/pulse.
botoes  in  4  button levels, already synchronised and debounced.
mem_address  out  4  address to the sequence ROM.
mem_data  in  4  ROM data output, registered in the ROM (1-clock read latency).
leds  out  4  last registered play.
pronto  out  1  round finished.
acertou  out  1  round won.
errou  out  1  wrong play.
timeout  out  1  round lost by inactivity.
db_estado  out  4  FSM state code.
db_contagem  out  4  current play index.

Behaviour:
- Reset, asynchronous: state INICIAL, mem_address=0, leds=0, all flags=0, timeout counter=0, edge-detect register=0.
- State codes:
  - INICIAL=0, PREPARA=1, ESPERA_MEM=2, ESPERA_JOGADA=3, REGISTRA=4, COMPARA=5, PROXIMO=6.
  - FIM_ACERTO=A, FIM_ERRO=E, FIM_TIMEOUT=F.
- INICIAL: wait for iniciar=1, then go to PREPARA.
- PREPARA: contador=0, leds=0, flags cleared, timeout counter=0. Go to ESPERA_MEM.
- ESPERA_MEM: exactly one cycle. It guarantees that mem_data reflects mem_address (ROM latency 1) before any compare. Go to ESPERA_JOGADA.
- ESPERA_JOGADA:
  - The timeout counter increments every cycle in this state.
  - A press event is defined as: registered previous botoes==0000 and current botoes!=0000. A press event moves the FSM to REGISTRA.
  - If the counter reaches TIMEOUT-1 with no press event, go to FIM_TIMEOUT.
  - If both happen in the same cycle, the press event wins.
- REGISTRA: jogada register <= botoes, leds <= botoes. Go to COMPARA.
- COMPARA:
  - Hit: jogada == mem_data, exact 4-bit compare, so a non-one-hot press is always a miss.
  - Miss: go to FIM_ERRO.
  - Hit with contador == SEQ_LEN-1: go to FIM_ACERTO.
  - Any other hit: go to PROXIMO.
- PROXIMO: contador increments, timeout counter cleared. Go to ESPERA_MEM.
- mem_address = contador, registered. db_contagem = contador.
- A held button produces exactly one press event; the next play requires a return to 0000 first.
- FIM_ACERTO: pronto=1, acertou=1.
- FIM_ERRO: pronto=1, errou=1.
- FIM_TIMEOUT: pronto=1, timeout=1.
- All FIM states hold their outputs and contador until iniciar=1, which goes to PREPARA (new round).
- iniciar is ignored in every non-INICIAL, non-FIM state.
- Button activity outside ESPERA_JOGADA is ignored, but the edge register still tracks botoes, so a press started early is not counted later.
- Widths: contador is 4 bits and never wraps within a round (max SEQ_LEN-1=15). The timeout counter is wide enough for TIMEOUT (clog2).
- Latency, press edge to flag: REGISTRA (+1), COMPARA (+2), FIM state visible on outputs (+3 cycles).
- Reset mid-round: immediate return to the reset values above; no flag survives.

Test Plan:
- The bench ROM model is registered, 16 words: 0001,0010,1000,0100,0100,1000,0010,0001, then the same 8 repeated. SEQ_LEN=16, TIMEOUT=100.
- Full win: reset, iniciar pulse, 16 correct presses, each held 3 cycles with 5 idle cycles between -> pronto=1, acertou=1, errou=0, db_contagem=F, db_estado=A, leds=0001.
- Miss at play 2: press 0001, 0010, then 0100 (expected 1000) -> errou=1, pronto=1, db_contagem=2, leds=0100, db_estado=E.
- Timeout: iniciar, no press -> timeout=1 and db_estado=F exactly 100 cycles after entering ESPERA_JOGADA. A press at cycle 99 -> REGISTRA, no timeout.
- Multi-button and hold: press 0011 at play 0 -> errou=1. In a new round, hold 0001 for 50 cycles -> exactly one play counted (db_contagem=1 after PROXIMO). Pulse iniciar mid-round -> no effect.
- Reset mid-round at play 5 -> all outputs 0, db_estado=0, mem_address=0. From FIM_ERRO, an iniciar pulse -> PREPARA, flags cleared, mem_address=0.

Source files
------------

// File: rtl/sequence_checker_if.sv
// Signal bundle between the PlaySeq round controller, the player's buttons/LEDs
// and the registered sequence ROM.
interface sequence_checker_if;
    logic       iniciar;
    logic [3:0] botoes;
    logic [3:0] mem_address;
    logic [3:0] mem_data;
    logic [3:0] leds;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;
    logic [3:0] db_contagem;

    modport master (
        input  iniciar, botoes, mem_data,
        output mem_address, leds, pronto, acertou, errou, timeout,
        output db_estado, db_contagem
    );

    modport slave (
        output iniciar, botoes, mem_data,
        input  mem_address, leds, pronto, acertou, errou, timeout,
        input  db_estado, db_contagem
    );
endinterface

// File: rtl/sequence_checker.sv
// PlaySeq round controller: walks the sequence ROM, compares each button press with
// the stored one-hot word and ends the round with a hit, miss or inactivity timeout.
module sequence_checker #(
    parameter int SEQ_LEN = 16,
    parameter int TIMEOUT = 5000
) (
    input  logic clock,
    input  logic reset,
    sequence_checker_if.master bus
);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        ESPERA_MEM    = 4'h2,
        ESPERA_JOGADA = 4'h3,
        REGISTRA      = 4'h4,
        COMPARA       = 4'h5,
        PROXIMO       = 4'h6,
        FIM_ACERTO    = 4'hA,
        FIM_ERRO      = 4'hE,
        FIM_TIMEOUT   = 4'hF
    } state_t;

    localparam int               TW           = $clog2(TIMEOUT + 1);
    localparam logic [3:0]       LAST_PLAY    = 4'(SEQ_LEN - 1);
    localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [3:0]    contador_q, contador_d;
    logic [TW-1:0] timeoutCnt_q, timeoutCnt_d;
    logic [3:0]    leds_q, leds_d;
    logic [3:0]    jogada_q, jogada_d;
    logic [3:0]    prevBotoes_q;
    logic          pressEvent;
    logic          startRound;

    // Only a rising activity edge counts, so a held button plays once.
    assign pressEvent = (prevBotoes_q == 4'b0000) && (bus.botoes != 4'b0000);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= INICIAL;
            contador_q   <= 4'd0;
            timeoutCnt_q <= '0;
            leds_q       <= 4'd0;
            jogada_q     <= 4'd0;
            prevBotoes_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            contador_q   <= contador_d;
            timeoutCnt_q <= timeoutCnt_d;
            leds_q       <= leds_d;
            jogada_q     <= jogada_d;
            prevBotoes_q <= bus.botoes;
        end
    end

    always_comb begin
        state_d      = state_q;
        contador_d   = contador_q;
        timeoutCnt_d = timeoutCnt_q;
        leds_d       = leds_q;
        jogada_d     = jogada_q;
        startRound   = 1'b0;

        case (state_q)
            INICIAL: begin
                if (bus.iniciar) begin
                    startRound = 1'b1;
                    state_d    = PREPARA;
                end
            end
            PREPARA: begin
                startRound = 1'b1;
                state_d    = ESPERA_MEM;
            end
            ESPERA_MEM: begin
                state_d = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                timeoutCnt_d = timeoutCnt_q + 1'b1;
                if (pressEvent) begin
                    state_d = REGISTRA;
                end else if (timeoutCnt_q == TIMEOUT_LAST) begin
                    state_d = FIM_TIMEOUT;
                end
            end
            REGISTRA: begin
                jogada_d = bus.botoes;
                leds_d   = bus.botoes;
                state_d  = COMPARA;
            end
            COMPARA: begin
                if (jogada_q != bus.mem_data) begin
                    state_d = FIM_ERRO;
                end else if (contador_q == LAST_PLAY) begin
                    state_d = FIM_ACERTO;
                end else begin
                    state_d = PROXIMO;
                end
            end
            PROXIMO: begin
                contador_d   = contador_q + 4'd1;
                timeoutCnt_d = '0;
                state_d      = ESPERA_MEM;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (bus.iniciar) begin
                    startRound = 1'b1;
                    state_d    = PREPARA;
                end
            end
            default: begin
                state_d = INICIAL;
            end
        endcase

        // Clearing on the way into PREPARA makes the new round visible immediately.
        if (startRound) begin
            contador_d   = 4'd0;
            timeoutCnt_d = '0;
            leds_d       = 4'd0;
            jogada_d     = 4'd0;
        end
    end

    assign bus.mem_address = contador_q;
    assign bus.db_contagem = contador_q;
    assign bus.db_estado   = state_q;
    assign bus.leds        = leds_q;
    assign bus.acertou     = (state_q == FIM_ACERTO);
    assign bus.errou       = (state_q == FIM_ERRO);
    assign bus.timeout     = (state_q == FIM_TIMEOUT);
    assign bus.pronto      = (state_q == FIM_ACERTO) || (state_q == FIM_ERRO) ||
                             (state_q == FIM_TIMEOUT);

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker: registered 16-word ROM model, win/miss/timeout
// rounds, held and multi-button presses, mid-round start and reset.
module tb_sequence_checker;

    localparam int SEQ_LEN = 16;
    localparam int TIMEOUT = 100;

    logic       clock = 1'b0;
    logic       reset;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] romWords [16];

    sequence_checker_if bus ();

    sequence_checker #(.SEQ_LEN(SEQ_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // ROM with one clock of read latency, as the real part has.
    always @(posedge clock) bus.mem_data <= romWords[bus.mem_address];

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] value, input int hold, input int idle);
        bus.botoes = value;
        repeat (hold) @(negedge clock);
        bus.botoes = 4'b0000;
        repeat (idle) @(negedge clock);
    endtask

    task automatic pulseIniciar();
        bus.iniciar = 1'b1;
        @(negedge clock);
        bus.iniciar = 1'b0;
    endtask

    task automatic waitState(input logic [3:0] target, input int budget);
        int n = 0;
        while (bus.db_estado !== target && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput("waitState", bus.db_estado, target);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        romWords = '{4'b0001, 4'b0010, 4'b1000, 4'b0100, 4'b0100, 4'b1000, 4'b0010, 4'b0001,
                     4'b0001, 4'b0010, 4'b1000, 4'b0100, 4'b0100, 4'b1000, 4'b0010, 4'b0001};
        reset       = 1'b1;
        bus.iniciar = 1'b0;
        bus.botoes  = 4'b0000;
        repeat (2) @(negedge clock);
        checkOutput("rst_estado", bus.db_estado, 4'h0);
        checkOutput("rst_addr", bus.mem_address, 4'h0);
        checkOutput("rst_leds", bus.leds, 4'h0);
        checkOutput("rst_pronto", bus.pronto, 1'b0);
        checkOutput("rst_flags", {bus.acertou, bus.errou, bus.timeout}, 3'b000);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] full winning round");
        pulseIniciar();
        checkOutput("win_prepara", bus.db_estado, 4'h1);
        for (int i = 0; i < SEQ_LEN; i++) begin
            waitState(4'h3, 20);
            if (i == 0) begin
                bus.botoes = romWords[0];
                @(negedge clock);
                checkOutput("lat_registra", bus.db_estado, 4'h4);
                @(negedge clock);
                checkOutput("lat_compara", bus.db_estado, 4'h5);
                @(negedge clock);
                checkOutput("lat_proximo", bus.db_estado, 4'h6);
                checkOutput("lat_pronto", bus.pronto, 1'b0);
                bus.botoes = 4'b0000;
                repeat (5) @(negedge clock);
                checkOutput("win_cont1", bus.db_contagem, 4'h1);
            end else begin
                applyStimulus(romWords[i], 3, 5);
            end
        end
        checkOutput("win_pronto", bus.pronto, 1'b1);
        checkOutput("win_acertou", bus.acertou, 1'b1);
        checkOutput("win_errou", bus.errou, 1'b0);
        checkOutput("win_contagem", bus.db_contagem, 4'hF);
        checkOutput("win_estado", bus.db_estado, 4'hA);
        checkOutput("win_leds", bus.leds, 4'b0001);

        $display("[TB] miss at play 2");
        pulseIniciar();
        waitState(4'h3, 20);
        applyStimulus(4'b0001, 3, 5);
        waitState(4'h3, 20);
        applyStimulus(4'b0010, 3, 5);
        waitState(4'h3, 20);
        applyStimulus(4'b0100, 3, 5);
        checkOutput("miss_errou", bus.errou, 1'b1);
        checkOutput("miss_pronto", bus.pronto, 1'b1);
        checkOutput("miss_acertou", bus.acertou, 1'b0);
        checkOutput("miss_contagem", bus.db_contagem, 4'h2);
        checkOutput("miss_leds", bus.leds, 4'b0100);
        checkOutput("miss_estado", bus.db_estado, 4'hE);
        repeat (4) @(negedge clock);
        checkOutput("miss_hold", bus.db_estado, 4'hE);

        $display("[TB] restart from FIM_ERRO and timeout");
        pulseIniciar();
        checkOutput("restart_estado", bus.db_estado, 4'h1);
        checkOutput("restart_flags", {bus.pronto, bus.errou}, 2'b00);
        checkOutput("restart_addr", bus.mem_address, 4'h0);
        checkOutput("restart_leds", bus.leds, 4'h0);
        waitState(4'h3, 20);
        repeat (TIMEOUT - 1) @(negedge clock);
        checkOutput("to_before", bus.db_estado, 4'h3);
        checkOutput("to_before_flag", bus.timeout, 1'b0);
        @(negedge clock);
        checkOutput("to_estado", bus.db_estado, 4'hF);
        checkOutput("to_flag", bus.timeout, 1'b1);
        checkOutput("to_pronto", bus.pronto, 1'b1);
        checkOutput("to_acertou", bus.acertou, 1'b0);

        $display("[TB] press in the last cycle before timeout");
        pulseIniciar();
        waitState(4'h3, 20);
        repeat (TIMEOUT - 1) @(negedge clock);
        bus.botoes = romWords[0];
        @(negedge clock);
        checkOutput("late_registra", bus.db_estado, 4'h4);
        checkOutput("late_timeout", bus.timeout, 1'b0);
        repeat (2) @(negedge clock);
        bus.botoes = 4'b0000;
        repeat (5) @(negedge clock);
        checkOutput("late_contagem", bus.db_contagem, 4'h1);
        for (int i = 1; i < 3; i++) begin
            waitState(4'h3, 20);
            applyStimulus(romWords[i], 3, 5);
        end

        $display("[TB] iniciar ignored mid-round");
        waitState(4'h3, 20);
        pulseIniciar();
        checkOutput("midini_estado", bus.db_estado, 4'h3);
        checkOutput("midini_contagem", bus.db_contagem, 4'h3);
        applyStimulus(romWords[3], 3, 5);
        waitState(4'h3, 20);
        applyStimulus(romWords[4], 3, 5);
        waitState(4'h3, 20);
        checkOutput("play5_contagem", bus.db_contagem, 4'h5);
        checkOutput("play5_addr", bus.mem_address, 4'h5);

        $display("[TB] reset mid-round");
        bus.botoes = romWords[5];
        @(negedge clock);
        checkOutput("pre_rst_estado", bus.db_estado, 4'h4);
        @(negedge clock);
        checkOutput("pre_rst_leds", bus.leds, 4'b1000);
        reset = 1'b1;
        #1;
        checkOutput("mrst_estado", bus.db_estado, 4'h0);
        checkOutput("mrst_addr", bus.mem_address, 4'h0);
        checkOutput("mrst_leds", bus.leds, 4'h0);
        checkOutput("mrst_contagem", bus.db_contagem, 4'h0);
        checkOutput("mrst_flags", {bus.pronto, bus.acertou, bus.errou, bus.timeout}, 4'h0);
        bus.botoes = 4'b0000;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] multi-button press");
        pulseIniciar();
        waitState(4'h3, 20);
        applyStimulus(4'b0011, 3, 5);
        checkOutput("multi_errou", bus.errou, 1'b1);
        checkOutput("multi_estado", bus.db_estado, 4'hE);
        checkOutput("multi_leds", bus.leds, 4'b0011);

        $display("[TB] held button counts once");
        pulseIniciar();
        waitState(4'h3, 20);
        bus.botoes = 4'b0001;
        repeat (50) @(negedge clock);
        checkOutput("hold_estado", bus.db_estado, 4'h3);
        checkOutput("hold_contagem", bus.db_contagem, 4'h1);
        bus.botoes = 4'b0000;
        repeat (3) @(negedge clock);
        checkOutput("release_contagem", bus.db_contagem, 4'h1);
        applyStimulus(4'b0010, 3, 5);
        checkOutput("after_hold_contagem", bus.db_contagem, 4'h2);
        checkOutput("after_hold_estado", bus.db_estado, 4'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
